ibuff_aligner: RTL and testbench
================================

IBUFF_ALIGNER -- requirements
Module: ibuff_aligner

Interface
- REQ-001: Parameter CACHE_LINE_SIZE, default 128: bits per buffered line; SHALL be a multiple of 32 and at least 64.
- REQ-002: Parameter INST_WIDTH, default 32: instruction width in bits.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset (asserted at 0).
- REQ-005: line_data  input  [CACHE_LINE_SIZE-1:0] x4  the four buffered lines, index 0..3.
- REQ-006: line_valid  input  4  per-slot valid bits from the line buffer.
- REQ-007: line_load  input  4  per-slot load strobes, the same strobes that write the line buffer.
- REQ-008: flush  input  1  redirect request.
- REQ-009: flush_pc  input  32  redirect target, word aligned.
- REQ-010: inst_valid  output  1  inst_data/inst_pc hold a valid instruction.
- REQ-011: inst_ready  input  1  the consumer accepts the instruction this cycle.
- REQ-012: inst_data  output  INST_WIDTH  the extracted instruction word.
- REQ-013: inst_pc  output  32  PC of inst_data.
- REQ-014: slot_release  output  4  one-cycle pulse when a slot is fully consumed.

Function
- REQ-015: State SHALL be: head (2 bits, slot index), offset (word index within line, log2(CACHE_LINE_SIZE/32) bits), pc (32 bits) and fresh (4 bits).
- REQ-016: line_load[i]=1 SHALL set fresh[i] at the next edge.
- REQ-017: inst_valid SHALL be fresh[head] & line_valid[head] & !flush, decoded combinationally from registered state.
- REQ-018: inst_data SHALL be bits [offset*32 +: 32] of line_data[head]; inst_pc SHALL be pc.
- REQ-019: Handshake: a transfer occurs when inst_valid & inst_ready; inst_data and inst_pc SHALL stay stable while inst_valid=1 and inst_ready=0.
- REQ-020: On each transfer, pc SHALL increase by 4 and offset SHALL increase by 1.
- REQ-021: On a transfer at the last word of the line:
  - offset SHALL wrap to 0;
  - head SHALL increment modulo 4 (3 wraps to 0);
  - fresh[head] SHALL clear;
  - slot_release[head] SHALL pulse for exactly that cycle.
- REQ-022: slot_release SHALL be zero in every other cycle, with at most one bit set at a time.
- REQ-023: Latency: a line_load in cycle N SHALL allow inst_valid=1 in cycle N+1 at the earliest.
- REQ-024: If line_load[head] coincides with the release of head, the load SHALL win and fresh[head] SHALL remain 1.
- REQ-025: flush SHALL take priority over every other event. At the next edge it SHALL:
  - clear fresh;
  - set head=0;
  - set offset=flush_pc word index within the line;
  - set pc=flush_pc.
- REQ-026: A line_load in the same cycle as flush SHALL be discarded.
- REQ-027: No slot_release SHALL pulse in a flush cycle.
- REQ-028: Empty case: when fresh[head]=0, the block SHALL stall with inst_valid=0 and hold all state.

Reset
- REQ-029: While rst=0, the block SHALL set head=0, offset=0, pc=0 and fresh=0, independent of clk.
- REQ-030: While rst=0, the outputs SHALL be inst_valid=0 and slot_release=0; inst_pc SHALL read 0.
- REQ-031: Reset asserted mid-transfer SHALL abort the transfer; no slot_release SHALL be emitted.
- REQ-032: Release of reset SHALL be synchronised by the system; the first edge after release SHALL behave as normal operation.

Configuration
- REQ-033: With IBUFF_ALIGNER_PERF_EN defined, the block SHALL add two outputs:
  - inst_count (32 bits): counts transfers;
  - stall_count (32 bits): counts cycles with inst_valid=0 and no flush.
- REQ-034: Both counters SHALL reset to 0, wrap modulo 2^32 and clear on flush.
- REQ-035: Without IBUFF_ALIGNER_PERF_EN, the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
- REQ-036: Reset then flush_pc=0x100; load slot 0 with words {0xA3,0xA2,0xA1,0xA0}; hold inst_ready=1 -> required response:
  - four transfers of 0xA0..0xA3 at pc 0x100..0x10C;
  - slot_release=0001 on the fourth transfer;
  - inst_valid=0 afterwards.
- REQ-037: flush_pc=0x208 -> the first instruction SHALL be word 2 of slot 0 at pc 0x208; slot 0 SHALL be released after 2 transfers.
- REQ-038: Load all 4 slots and consume 16 instructions -> releases SHALL be 0001, 0010, 0100, 1000; head SHALL wrap to 0 with pc +0x40.
- REQ-039: inst_ready=0 for 3 cycles with inst_valid=1 -> inst_data and inst_pc SHALL be stable; no pc advance.
- REQ-040: flush asserted in the same cycle as line_load[1] and a transfer -> no release; fresh=0000; pc=flush_pc next cycle.
- REQ-041: With IBUFF_ALIGNER_PERF_EN defined: 8 transfers plus 5 empty cycles -> inst_count=8 and stall_count=5; both counters 0 after flush.

Source files
------------

// File: rtl/ibuff_aligner.sv
// Instruction-buffer aligner: walks the four buffered cache lines word by word and presents one instruction at a time.
// Optional transfer/stall performance counters are compiled in when IBUFF_ALIGNER_PERF_EN is defined.
module ibuff_aligner #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int INST_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CACHE_LINE_SIZE-1:0] line_data [4],
  input  logic [3:0]                 line_valid,
  input  logic [3:0]                 line_load,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_WIDTH-1:0]      inst_data,
  output logic [31:0]                inst_pc,
  output logic [3:0]                 slot_release
`ifdef IBUFF_ALIGNER_PERF_EN
  ,
  output logic [31:0]                inst_count,
  output logic [31:0]                stall_count
`endif
);

  localparam int WORDS = CACHE_LINE_SIZE / 32;
  localparam int OFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  logic [1:0]       head_q, head_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic [31:0]      pc_q, pc_d;
  logic [3:0]       fresh_q, fresh_d;

  logic             xfer;
  logic             last_word;
  logic [31:0]      word_sel;
  logic [29:0]      flush_word;
  logic [OFF_W-1:0] flush_off;

  // flush wins over everything, so it also masks the handshake
  assign inst_valid = fresh_q[head_q] & line_valid[head_q] & ~flush;
  assign xfer       = inst_valid & inst_ready;
  assign last_word  = (offset_q == LAST_OFF);

  assign word_sel  = line_data[head_q][{offset_q, 5'b0} +: 32];
  assign inst_data = INST_WIDTH'(word_sel);
  assign inst_pc   = pc_q;

  // Modulo keeps the word index correct for non-power-of-two line sizes too
  assign flush_word = flush_pc[31:2] % 30'(WORDS);
  assign flush_off  = flush_word[OFF_W-1:0];

  always_comb begin
    slot_release = 4'b0000;
    if (xfer && last_word) begin
      slot_release = 4'b0001 << head_q;
    end
  end

  always_comb begin
    head_d   = head_q;
    offset_d = offset_q;
    pc_d     = pc_q;
    fresh_d  = fresh_q;
    if (flush) begin
      fresh_d  = 4'b0000;
      head_d   = 2'd0;
      offset_d = flush_off;
      pc_d     = flush_pc;
    end else begin
      if (xfer) begin
        pc_d = pc_q + 32'd4;
        if (last_word) begin
          offset_d        = '0;
          head_d          = head_q + 2'd1;
          fresh_d[head_q] = 1'b0;
        end else begin
          offset_d = offset_q + OFF_W'(1);
        end
      end
      // A load landing on the slot being released keeps it fresh
      fresh_d = fresh_d | line_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= 2'd0;
      offset_q <= '0;
      pc_q     <= 32'd0;
      fresh_q  <= 4'b0000;
    end else begin
      head_q   <= head_d;
      offset_q <= offset_d;
      pc_q     <= pc_d;
      fresh_q  <= fresh_d;
    end
  end

`ifdef IBUFF_ALIGNER_PERF_EN
  logic [31:0] inst_count_q, inst_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    inst_count_d  = inst_count_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      inst_count_d  = 32'd0;
      stall_count_d = 32'd0;
    end else begin
      inst_count_d  = inst_count_q + 32'(xfer);
      stall_count_d = stall_count_q + 32'(~inst_valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_count_q  <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      inst_count_q  <= inst_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign inst_count  = inst_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ibuff_aligner.sv
// Scoreboard bench for ibuff_aligner: expected transfers are queued as stimulus is driven and compared at each handshake.
// Builds with or without IBUFF_ALIGNER_PERF_EN; the counter test is compiled only when the macro is defined.
module tb_ibuff_aligner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] line_data [4];
  logic [3:0]   line_valid;
  logic [3:0]   line_load;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_data;
  logic [31:0]  inst_pc;
  logic [3:0]   slot_release;
`ifdef IBUFF_ALIGNER_PERF_EN
  logic [31:0]  inst_count;
  logic [31:0]  stall_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [3:0]  rel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ibuff_aligner #(.CACHE_LINE_SIZE(128), .INST_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_data    (line_data),
    .line_valid   (line_valid),
    .line_load    (line_load),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .slot_release (slot_release)
`ifdef IBUFF_ALIGNER_PERF_EN
    ,
    .inst_count   (inst_count),
    .stall_count  (stall_count)
`endif
  );

  // Every handshake pops one expected transfer; every other cycle must show no release
  always @(negedge clk) begin
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: data=%h pc=%h, required no transfer", inst_data, inst_pc);
      end else begin
        mon_e = sb.pop_front();
        if (inst_data !== mon_e.data) begin
          errors++;
          $display("FAIL xfer_data: actual=%h required=%h (pc %h)", inst_data, mon_e.data, mon_e.pc);
        end
        checks++;
        if (inst_pc !== mon_e.pc) begin
          errors++;
          $display("FAIL xfer_pc: actual=%h required=%h", inst_pc, mon_e.pc);
        end
        checks++;
        if (slot_release !== mon_e.rel) begin
          errors++;
          $display("FAIL xfer_release: actual=%b required=%b (pc %h)", slot_release, mon_e.rel, mon_e.pc);
        end
      end
    end else begin
      checks++;
      if (slot_release !== 4'b0000) begin
        errors++;
        $display("FAIL idle_release: actual=%b required=0000", slot_release);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int s, input logic [31:0] base);
    line_data[s] = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] pc, input logic [3:0] rel);
    exp_t e;
    e.data = d;
    e.pc   = pc;
    e.rel  = rel;
    sb.push_back(e);
  endtask

  task automatic load(input logic [3:0] mask);
    line_load  = mask;
    line_valid = line_valid | mask;
    tick();
    line_load  = 4'b0000;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: actual=%b required=0", inst_valid);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (inst_pc !== pc) begin
      errors++;
      $display("FAIL flush_pc: actual=%h required=%h", inst_pc, pc);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d transfers missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    flush      = 1'b0;
    flush_pc   = 32'd0;
    inst_ready = 1'b1;
    line_valid = 4'b1111;
    line_load  = 4'b1111;
    for (int s = 0; s < 4; s++) line_data[s] = '0;
    #2;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: actual=%b required=0", inst_valid); end
    checks++;
    if (inst_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: actual=%h required=0", inst_pc); end
    checks++;
    if (slot_release !== 4'b0000) begin errors++; $display("FAIL reset_release: actual=%b required=0000", slot_release); end
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b1;
    line_load  = 4'b0000;
    inst_ready = 1'b0;
    line_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_load_ignored: actual=%b required=0", inst_valid); end
  endtask

  task automatic test_basic();
    do_flush(32'h100);
    set_line(0, 32'hA0);
    line_load     = 4'b0001;
    line_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL latency_early: actual=%b required=0", inst_valid); end
    @(posedge clk);
    #1;
    line_load = 4'b0000;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL latency_n1: actual=%b required=1", inst_valid); end
    for (int w = 0; w < 4; w++)
      push(32'hA0 + 32'(w), 32'h100 + 32'(4 * w), (w == 3) ? 4'b0001 : 4'b0000);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    wait_drain("basic", 12);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_after: actual=%b required=0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_offset();
    do_flush(32'h208);
    set_line(0, 32'hB0);
    push(32'hB2, 32'h208, 4'b0000);
    push(32'hB3, 32'h20C, 4'b0001);
    load(4'b0001);
    inst_ready = 1'b1;
    wait_drain("offset", 10);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL offset_empty_after: actual=%b required=0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_flush(32'h400);
    for (int s = 0; s < 4; s++) begin
      set_line(s, 32'hC000_0000 + 32'(s * 256));
      for (int w = 0; w < 4; w++)
        push(32'hC000_0000 + 32'(s * 256 + w), 32'h400 + 32'(16 * s + 4 * w),
             (w == 3) ? (4'b0001 << s) : 4'b0000);
    end
    load(4'b1111);
    inst_ready = 1'b1;
    wait_drain("wrap", 40);
    inst_ready = 1'b0;
    checks++;
    if (inst_pc !== 32'h440) begin errors++; $display("FAIL wrap_pc: actual=%h required=00000440", inst_pc); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_all_released: actual=%b required=0", inst_valid); end
    set_line(0, 32'hD0);
    push(32'hD0, 32'h440, 4'b0000);
    @(posedge clk);
    #1;
    load(4'b0001);
    inst_ready = 1'b1;
    wait_drain("wrap_head0", 8);
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_flush(32'h500);
    set_line(0, 32'h5000);
    load(4'b0001);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: actual=%b required=1", inst_valid); end
      checks++;
      if (inst_data !== 32'h5000) begin errors++; $display("FAIL bp_data: actual=%h required=00005000", inst_data); end
      checks++;
      if (inst_pc !== 32'h500) begin errors++; $display("FAIL bp_pc: actual=%h required=00000500", inst_pc); end
      @(posedge clk);
      #1;
    end
    for (int w = 0; w < 4; w++)
      push(32'h5000 + 32'(w), 32'h500 + 32'(4 * w), (w == 3) ? 4'b0001 : 4'b0000);
    inst_ready = 1'b1;
    wait_drain("bp", 12);
    inst_ready = 1'b0;
  endtask

  task automatic test_load_wins();
    do_flush(32'h60C);
    set_line(0, 32'h6000);
    load(4'b0001);
    push(32'h6003, 32'h60C, 4'b0001);
    inst_ready = 1'b1;
    line_load  = 4'b0001;
    tick();
    line_load  = 4'b0000;
    inst_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL loadwin_release: %0d transfers missing, required 0", sb.size()); sb.delete(); end
    for (int s = 1; s < 4; s++) begin
      set_line(s, 32'h6000 + 32'(s * 256));
      for (int w = 0; w < 4; w++)
        push(32'h6000 + 32'(s * 256 + w), 32'h610 + 32'(16 * (s - 1) + 4 * w),
             (w == 3) ? (4'b0001 << s) : 4'b0000);
    end
    // slot 0 must still be fresh from the load that coincided with its release
    for (int w = 0; w < 4; w++)
      push(32'h6000 + 32'(w), 32'h640 + 32'(4 * w), (w == 3) ? 4'b0001 : 4'b0000);
    load(4'b1110);
    inst_ready = 1'b1;
    wait_drain("loadwin", 60);
    inst_ready = 1'b0;
  endtask

  task automatic test_flush_collide();
    do_flush(32'h70C);
    set_line(0, 32'h7000);
    set_line(1, 32'h7100);
    load(4'b0001);
    flush         = 1'b1;
    flush_pc      = 32'h900;
    line_load     = 4'b0010;
    line_valid[1] = 1'b1;
    inst_ready    = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_valid: actual=%b required=0", inst_valid); end
    checks++;
    if (slot_release !== 4'b0000) begin errors++; $display("FAIL collide_release: actual=%b required=0000", slot_release); end
    @(posedge clk);
    #1;
    flush      = 1'b0;
    line_load  = 4'b0000;
    checks++;
    if (inst_pc !== 32'h900) begin errors++; $display("FAIL collide_pc: actual=%h required=00000900", inst_pc); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_fresh0: actual=%b required=0", inst_valid); end
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    for (int w = 0; w < 4; w++)
      push(32'h7000 + 32'(w), 32'h900 + 32'(4 * w), (w == 3) ? 4'b0001 : 4'b0000);
    load(4'b0001);
    inst_ready = 1'b1;
    wait_drain("collide", 12);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_fresh1: actual=%b required=0", inst_valid); end
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_flush(32'hA0C);
    set_line(0, 32'hA000);
    load(4'b0001);
    inst_ready = 1'b1;
    rst        = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: actual=%b required=0", inst_valid); end
    checks++;
    if (slot_release !== 4'b0000) begin errors++; $display("FAIL midrst_release: actual=%b required=0000", slot_release); end
    checks++;
    if (inst_pc !== 32'd0) begin errors++; $display("FAIL midrst_pc: actual=%h required=0", inst_pc); end
    @(posedge clk);
    #1;
    rst        = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL postrst_valid: actual=%b required=0", inst_valid); end
    @(posedge clk);
    #1;
    push(32'hA000, 32'h0, 4'b0000);
    load(4'b0001);
    inst_ready = 1'b1;
    wait_drain("postrst", 8);
    inst_ready = 1'b0;
  endtask

`ifdef IBUFF_ALIGNER_PERF_EN
  task automatic test_perf();
    do_flush(32'h800);
    checks++;
    if (inst_count !== 32'd0) begin errors++; $display("FAIL perf_inst_clear: actual=%0d required=0", inst_count); end
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL perf_stall_clear: actual=%0d required=0", stall_count); end
    repeat (4) tick();
    set_line(0, 32'h8000);
    set_line(1, 32'h8100);
    for (int k = 0; k < 8; k++)
      push(32'h8000 + 32'((k / 4) * 256 + k % 4), 32'h800 + 32'(4 * k),
           (k == 3) ? 4'b0001 : ((k == 7) ? 4'b0010 : 4'b0000));
    load(4'b0011);
    inst_ready = 1'b1;
    wait_drain("perf", 20);
    inst_ready = 1'b0;
    checks++;
    if (inst_count !== 32'd8) begin errors++; $display("FAIL perf_inst_count: actual=%0d required=8", inst_count); end
    checks++;
    if (stall_count !== 32'd5) begin errors++; $display("FAIL perf_stall_count: actual=%0d required=5", stall_count); end
    do_flush(32'h0);
    checks++;
    if (inst_count !== 32'd0) begin errors++; $display("FAIL perf_inst_flush: actual=%0d required=0", inst_count); end
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL perf_stall_flush: actual=%0d required=0", stall_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_wrap();
    test_backpressure();
    test_load_wins();
    test_flush_collide();
    test_reset_mid();
`ifdef IBUFF_ALIGNER_PERF_EN
    test_perf();
`endif
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
